cbfp_bitrev_reorder: RTL and testbench
======================================

Name: cbfp_bitrev_reorder

Overview:
- Frame-level ping-pong reorder buffer directly downstream of the CBFP1 normalisation stage.
- Accepts 16 normalised complex samples plus their per-sample block exponent every valid cycle, in natural order.
- Stores one full frame per bank, then replays the frame in bit-reversed sample order so the next butterfly/output stage sees natural-frequency order.
- Exponents travel with their samples unchanged.

Parameters:
- DATA_W, 12, width of each re/im sample (signed <6.6>)
- IDX_W, 5, width of the per-sample exponent (matches $clog2(25))
- NCHAN, 16, samples per beat
- NPOINT, 512, samples per frame
- NBEATS, NPOINT/NCHAN = 32, beats per frame
- ADDR_W, $clog2(NPOINT) = 9, sample-index width used for bit reversal

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- valid_in  in  1  input beat valid
- data_re_in  in  DATA_W x NCHAN  signed real samples, lane l = sample beat*16+l
- data_im_in  in  DATA_W x NCHAN  signed imaginary samples
- idx_in  in  IDX_W x NCHAN  exponent per sample
- data_re_out  out  DATA_W x NCHAN  reordered real samples
- data_im_out  out  DATA_W x NCHAN  reordered imaginary samples
- idx_out  out  IDX_W x NCHAN  exponent accompanying each output sample
- valid_out  out  1  output beat valid

Behaviour:
- Reset (async assert, sync release): all outputs 0, valid_out 0. wr_bank=0, wr_beat=0, rd_beat=0. Both bank_full flags 0. Read FSM in IDLE. Storage contents don't care.
- Write side:
  - On valid_in, lanes l=0..15 store to bank wr_bank at address wr_beat*16+l; wr_beat increments.
  - When wr_beat wraps 31->0: set bank_full[wr_bank] and toggle wr_bank.
  - Gaps in valid_in are allowed; the frame simply takes longer.
- Read FSM:
  - IDLE: when any bank_full is set, go to DRAIN with rd_bank = the oldest full bank.
  - DRAIN: output beat b, lane l = stored sample at address bitrev9(b*16+l) of rd_bank, together with its idx.
  - valid_out is high for 32 consecutive cycles. At b=31, clear bank_full[rd_bank].
  - If the other bank is full in that same cycle, continue DRAIN on it with no bubble; otherwise return to IDLE.
- Outputs are registered.
- Latency: first valid_out asserts 2 cycles after the clock edge that registers the 32nd input beat (1 cycle to set full and enter DRAIN, 1 registered output).
- Continuous input (valid_in held high) yields continuous valid_out after the initial latency.
- Overrun: the writer reaching wrap on a bank still full cannot occur at rate ≤1 beat/clk, since a fill takes ≥32 cycles and a drain takes exactly 32. No stall port is provided.
- Simultaneous write-complete and drain-complete in one cycle: both flag updates apply; set and clear target different banks.
- Arithmetic: none; data and idx pass bit-exact.
- Reset mid-frame: the partial frame is discarded and the next valid_in starts at beat 0, bank 0.

Optional Feature:
- Macro SOF_MARK_EN.
- Defined: adds output port sof_out (1 bit, reset 0). It is high together with valid_out on beat 0 of each drained frame, and low otherwise.
- Undefined: no sof_out port and no related logic.

Decomposition:
- Shared package cbfp_pkg holds DATA_W, IDX_W, NCHAN, NPOINT constants, a sample struct {re, im, idx}, and a bitrev function parameterised on ADDR_W.
- One natural sub-module: cbfp_frame_bank, one storage bank with 16-lane natural-order write and 16-lane arbitrary-address read. It is instantiated twice.

Test Plan:
- Reset then one frame with re=sample index n (0..511), im=-n, idx=n%25 → after 2-cycle latency, 32 beats; beat 0 lanes carry re=0,256,128,384,...; beat 31 lane 15 re=511; idx matches.
- Three back-to-back frames with valid_in held high → valid_out continuous for 96 cycles with no bubble; frame k content is offset by k*1000.
- Frame with valid_in toggling 1/0 each cycle → output appears only after the 32nd accepted beat; content is correct.
- Assert rstn low at input beat 17 of a frame, then feed a full frame → only the new frame is output; valid_out stays 0 during and after reset until completion.
- Extreme values (re=+2047, im=-2048, idx=24 on all lanes) → output bit-exact.
- With SOF_MARK_EN, two consecutive frames → sof_out high exactly on output cycles 0 and 32.

Source files
------------

// File: rtl/cbfp_pkg.sv
// Shared constants, sample type and bit-reversal helper for the CBFP1 reorder stage.
package cbfp_pkg;

  localparam int DATA_W = 12;
  localparam int IDX_W  = 5;
  localparam int NCHAN  = 16;
  localparam int NPOINT = 512;
  localparam int NBEATS = NPOINT / NCHAN;
  localparam int ADDR_W = $clog2(NPOINT);
  localparam int BEAT_W = $clog2(NBEATS);
  localparam int LANE_W = $clog2(NCHAN);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
    logic        [IDX_W-1:0]  idx;
  } sample_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] rev;
    for (int i = 0; i < ADDR_W; i++) begin
      rev[i] = addr[ADDR_W-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/cbfp_frame_bank.sv
// One frame of sample storage: a whole 16-lane beat is written in natural order,
// while each of the 16 read lanes may address any sample of the frame.
module cbfp_frame_bank
  import cbfp_pkg::*;
(
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [BEAT_W-1:0]             wr_beat,
  input  sample_t [NCHAN-1:0]           wr_data,
  input  logic [NCHAN-1:0][ADDR_W-1:0]  rd_addr,
  output sample_t [NCHAN-1:0]           rd_data
);

  // Contents are never reset; the frame flags in the parent decide what is valid.
  sample_t mem [NPOINT];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < NCHAN; l++) begin
        mem[{wr_beat, LANE_W'(l)}] <= wr_data[l];
      end
    end
  end

  for (genvar l = 0; l < NCHAN; l++) begin : g_rd
    assign rd_data[l] = mem[rd_addr[l]];
  end

endmodule

// File: rtl/cbfp_bitrev_reorder.sv
// Ping-pong frame buffer that replays each 512-sample frame in bit-reversed order.
// Optional macro SOF_MARK_EN adds sof_out, flagging beat 0 of every drained frame.
module cbfp_bitrev_reorder
  import cbfp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      valid_in,
  input  logic [NCHAN*DATA_W-1:0]   data_re_in,
  input  logic [NCHAN*DATA_W-1:0]   data_im_in,
  input  logic [NCHAN*IDX_W-1:0]    idx_in,
  output logic [NCHAN*DATA_W-1:0]   data_re_out,
  output logic [NCHAN*DATA_W-1:0]   data_im_out,
  output logic [NCHAN*IDX_W-1:0]    idx_out,
  output logic                      valid_out
`ifdef SOF_MARK_EN
  ,
  output logic                      sof_out
`endif
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  logic                         wr_bank;
  logic [BEAT_W-1:0]            wr_beat;
  logic                         wr_wrap;
  logic [1:0]                   bank_full;
  logic [1:0]                   set_mask;
  logic [1:0]                   clr_mask;

  rd_state_e                    state, state_nxt;
  logic                         rd_bank, rd_bank_nxt;
  logic [BEAT_W-1:0]            rd_beat, rd_beat_nxt;

  sample_t [NCHAN-1:0]          wr_data;
  sample_t [NCHAN-1:0]          rd_data0, rd_data1, rd_sel;
  logic [NCHAN-1:0][ADDR_W-1:0] rd_addr;

  for (genvar l = 0; l < NCHAN; l++) begin : g_lane
    assign wr_data[l] = '{re:  data_re_in[l*DATA_W +: DATA_W],
                          im:  data_im_in[l*DATA_W +: DATA_W],
                          idx: idx_in[l*IDX_W +: IDX_W]};
    assign rd_addr[l] = bitrev({rd_beat, LANE_W'(l)});
  end

  cbfp_frame_bank u_bank0 (
    .clk     (clk),
    .wr_en   (valid_in && !wr_bank),
    .wr_beat (wr_beat),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  cbfp_frame_bank u_bank1 (
    .clk     (clk),
    .wr_en   (valid_in && wr_bank),
    .wr_beat (wr_beat),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  assign rd_sel   = rd_bank ? rd_data1 : rd_data0;
  assign wr_wrap  = valid_in && (wr_beat == LAST_BEAT);
  assign set_mask = wr_wrap ? (2'b01 << wr_bank) : 2'b00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank <= 1'b0;
      wr_beat <= '0;
    end else if (valid_in) begin
      wr_beat <= wr_beat + BEAT_W'(1);
      if (wr_wrap) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Set and clear never target the same bank, so both may apply in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_beat <= '0;
    end else begin
      state   <= state_nxt;
      rd_bank <= rd_bank_nxt;
      rd_beat <= rd_beat_nxt;
    end
  end

  // With both banks full, the one the writer returns to next is the older frame.
  always_comb begin
    state_nxt   = state;
    rd_bank_nxt = rd_bank;
    rd_beat_nxt = rd_beat;
    clr_mask    = 2'b00;
    case (state)
      RD_IDLE: begin
        if (|bank_full) begin
          state_nxt   = RD_DRAIN;
          rd_bank_nxt = (&bank_full) ? wr_bank : bank_full[1];
          rd_beat_nxt = '0;
        end
      end
      RD_DRAIN: begin
        rd_beat_nxt = rd_beat + BEAT_W'(1);
        if (rd_beat == LAST_BEAT) begin
          clr_mask[rd_bank] = 1'b1;
          if (bank_full[~rd_bank]) begin
            rd_bank_nxt = ~rd_bank;
          end else begin
            state_nxt = RD_IDLE;
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out   <= 1'b0;
      data_re_out <= '0;
      data_im_out <= '0;
      idx_out     <= '0;
    end else begin
      valid_out <= (state == RD_DRAIN);
      if (state == RD_DRAIN) begin
        for (int l = 0; l < NCHAN; l++) begin
          data_re_out[l*DATA_W +: DATA_W] <= rd_sel[l].re;
          data_im_out[l*DATA_W +: DATA_W] <= rd_sel[l].im;
          idx_out[l*IDX_W +: IDX_W]       <= rd_sel[l].idx;
        end
      end
    end
  end

`ifdef SOF_MARK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sof_out <= 1'b0;
    end else begin
      sof_out <= (state == RD_DRAIN) && (rd_beat == '0);
    end
  end
`endif

endmodule

// File: tb/tb_cbfp_bitrev_reorder.sv
// Scoreboard bench: a frame-level reference model predicts every output beat and its cycle.
module tb_cbfp_bitrev_reorder;
  import cbfp_pkg::*;

  localparam int RE_W = NCHAN * DATA_W;
  localparam int IX_W = NCHAN * IDX_W;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            valid_in = 1'b0;
  logic [RE_W-1:0] data_re_in = '0;
  logic [RE_W-1:0] data_im_in = '0;
  logic [IX_W-1:0] idx_in = '0;
  logic [RE_W-1:0] data_re_out;
  logic [RE_W-1:0] data_im_out;
  logic [IX_W-1:0] idx_out;
  logic            valid_out;
`ifdef SOF_MARK_EN
  logic            sof_out;
`endif

  cbfp_bitrev_reorder dut (
    .clk         (clk),
    .rstn        (rstn),
    .valid_in    (valid_in),
    .data_re_in  (data_re_in),
    .data_im_in  (data_im_in),
    .idx_in      (idx_in),
    .data_re_out (data_re_out),
    .data_im_out (data_im_out),
    .idx_out     (idx_out),
    .valid_out   (valid_out)
`ifdef SOF_MARK_EN
    ,
    .sof_out     (sof_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RE_W-1:0] re;
    logic [RE_W-1:0] im;
    logic [IX_W-1:0] idx;
    int              cyc;
    bit              sof;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   lastStart = -1000;
  int   mcount = 0;

  logic [DATA_W-1:0] fre [NPOINT];
  logic [DATA_W-1:0] fim [NPOINT];
  logic [IDX_W-1:0]  fidx [NPOINT];
  logic [DATA_W-1:0] mre [NPOINT];
  logic [DATA_W-1:0] mim [NPOINT];
  logic [IDX_W-1:0]  midx [NPOINT];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int revBits(input int k);
    int r = 0;
    for (int i = 0; i < ADDR_W; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  // Frame-level reference: output sample k of a frame is input sample bitrev(k);
  // a frame starts 2 cycles after its last beat, or right after the previous drain.
  task automatic modelAccept(input int b);
    int   start;
    int   src;
    exp_t e;
    for (int l = 0; l < NCHAN; l++) begin
      mre[mcount*NCHAN+l]  = fre[b*NCHAN+l];
      mim[mcount*NCHAN+l]  = fim[b*NCHAN+l];
      midx[mcount*NCHAN+l] = fidx[b*NCHAN+l];
    end
    mcount++;
    if (mcount == NBEATS) begin
      start = cyc + 3;
      if (lastStart + NBEATS > start) start = lastStart + NBEATS;
      lastStart = start;
      for (int ob = 0; ob < NBEATS; ob++) begin
        for (int l = 0; l < NCHAN; l++) begin
          src = revBits(ob * NCHAN + l);
          e.re[l*DATA_W +: DATA_W] = mre[src];
          e.im[l*DATA_W +: DATA_W] = mim[src];
          e.idx[l*IDX_W +: IDX_W]  = midx[src];
        end
        e.cyc = start + ob;
        e.sof = (ob == 0);
        expq.push_back(e);
      end
      mcount = 0;
    end
  endtask

  task automatic applyStimulus(input logic v, input int b);
    @(negedge clk);
    valid_in = v;
    for (int l = 0; l < NCHAN; l++) begin
      if (v) begin
        data_re_in[l*DATA_W +: DATA_W] = fre[b*NCHAN+l];
        data_im_in[l*DATA_W +: DATA_W] = fim[b*NCHAN+l];
        idx_in[l*IDX_W +: IDX_W]       = fidx[b*NCHAN+l];
      end else begin
        data_re_in[l*DATA_W +: DATA_W] = DATA_W'($urandom);
        data_im_in[l*DATA_W +: DATA_W] = DATA_W'($urandom);
        idx_in[l*IDX_W +: IDX_W]       = IDX_W'($urandom);
      end
    end
    if (v) modelAccept(b);
  endtask

  // gapMode 0: continuous, 1: idle cycle after every beat, 2: random idle runs.
  task automatic sendFrame(input int gapMode, input int stopAt);
    for (int b = 0; b < stopAt; b++) begin
      if (gapMode == 2) repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 0);
      applyStimulus(1'b1, b);
      if (gapMode == 1) applyStimulus(1'b0, 0);
    end
  endtask

  task automatic fillFrame(input int mode, input int k);
    for (int n = 0; n < NPOINT; n++) begin
      case (mode)
        0: begin
          fre[n]  = DATA_W'(n + k * 1000);
          fim[n]  = DATA_W'(-n - k * 1000);
          fidx[n] = IDX_W'((n + k) % 25);
        end
        1: begin
          fre[n]  = 12'h7FF;
          fim[n]  = 12'h800;
          fidx[n] = IDX_W'(24);
        end
        default: begin
          fre[n]  = DATA_W'($urandom);
          fim[n]  = DATA_W'($urandom);
          fidx[n] = IDX_W'($urandom_range(0, 24));
        end
      endcase
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid_out"}, 256'(valid_out), 256'(0));
    checkOutput({tag, "_data_re_out"}, 256'(data_re_out), 256'(0));
    checkOutput({tag, "_data_im_out"}, 256'(data_im_out), 256'(0));
    checkOutput({tag, "_idx_out"}, 256'(idx_out), 256'(0));
`ifdef SOF_MARK_EN
    checkOutput({tag, "_sof_out"}, 256'(sof_out), 256'(0));
`endif
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0;
    valid_in = 1'b0;
    mcount = 0;
    lastStart = -1000;
    #1;
    checkResetOutputs("rst_assert");
    repeat (3) @(negedge clk);
    checkResetOutputs("rst_hold");
    rstn = 1'b1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expq.size() != 0 && n < 400) begin
      applyStimulus(1'b0, 0);
      n++;
    end
    if (expq.size() != 0) checkOutput("drain_timeout", 256'(expq.size()), 256'(0));
    repeat (4) applyStimulus(1'b0, 0);
  endtask

  // Monitor: every valid_out beat must match the head of the scoreboard in content and cycle.
  always @(negedge clk) begin
    if (valid_out) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_valid_out", 256'(valid_out), 256'(0));
      end else begin
        mon_e = expq.pop_front();
        checkOutput("out_cycle", 256'(cyc), 256'(mon_e.cyc));
        checkOutput("data_re_out", 256'(data_re_out), 256'(mon_e.re));
        checkOutput("data_im_out", 256'(data_im_out), 256'(mon_e.im));
        checkOutput("idx_out", 256'(idx_out), 256'(mon_e.idx));
`ifdef SOF_MARK_EN
        checkOutput("sof_out", 256'(sof_out), 256'(mon_e.sof));
`endif
      end
    end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
      checkOutput("missing_valid_out", 256'(valid_out), 256'(1));
      mon_e = expq.pop_front();
    end
  end

  initial begin
    $display("[TB] reset");
    doReset();

    $display("[TB] ramp frame");
    fillFrame(0, 0);
    sendFrame(0, NBEATS);
    waitDrain();

    $display("[TB] three back-to-back frames");
    for (int k = 0; k < 3; k++) begin
      fillFrame(0, k);
      sendFrame(0, NBEATS);
    end
    waitDrain();

    $display("[TB] toggling valid_in");
    fillFrame(0, 5);
    sendFrame(1, NBEATS);
    waitDrain();

    $display("[TB] reset at beat 17");
    fillFrame(2, 0);
    sendFrame(0, 17);
    doReset();
    fillFrame(0, 7);
    sendFrame(0, NBEATS);
    waitDrain();

    $display("[TB] extreme values");
    fillFrame(1, 0);
    sendFrame(0, NBEATS);
    waitDrain();

    $display("[TB] random frames with random gaps");
    for (int k = 0; k < 3; k++) begin
      fillFrame(2, k);
      sendFrame(2, NBEATS);
    end
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
